// File: rtl/histogram_equalizer_core.sv
// -----------------------------------------------------------------------------
// histogram_equalizer_core
//
// Histogram-equalization engine for one frame of exactly N = 2^PIX_CNT_LOG2
// pixels. Each frame runs four phases in order:
//   CLEAR  zero the L = 2^PIXEL_W histogram bins, one bin per cycle
//   ACCUM  count N incoming pixels into the bins
//   CDF    accumulate the bins into a cumulative count and build the LUT
//   APPLY  remap N incoming pixels through the LUT (latency 1)
// In identity mode the LUT becomes lut[i] = i, so pixels pass through unchanged.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse; begins a frame when idle
//   mode       0 = equalize, 1 = identity LUT; latched on an accepted start
//   in_valid   input pixel valid
//   in_pixel   input pixel value
//   in_ready   the block accepts in_pixel this cycle
//   out_valid  remapped pixel valid
//   out_pixel  remapped pixel
//   out_ready  downstream accepts out_pixel
//   busy       high in every state except IDLE
//   done       one-cycle pulse when the frame finishes
//   phase      current state encoding, for debug or a VGA overlay
// -----------------------------------------------------------------------------
module histogram_equalizer_core #(
  parameter int PIXEL_W      = 8,
  parameter int PIX_CNT_LOG2 = 16,
  parameter int CNT_W        = PIX_CNT_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] out_pixel,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [2:0]         phase
);

  localparam int L      = 1 << PIXEL_W;
  localparam int PROD_W = CNT_W + PIXEL_W;
  localparam logic [CNT_W-1:0]   N_CNT    = CNT_W'(1 << PIX_CNT_LOG2);
  localparam logic [CNT_W-1:0]   N_LAST   = CNT_W'((1 << PIX_CNT_LOG2) - 1);
  localparam logic [PIXEL_W-1:0] IDX_LAST = '1;
  localparam logic [PROD_W-1:0]  L_MAX    = PROD_W'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_CDF   = 3'd3,
    S_APPLY = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_mode;
  logic [PIXEL_W-1:0]   r_idx;        // bin index while clearing and building the CDF
  logic [CNT_W-1:0]     r_cnt;        // pixels accepted in ACCUM / APPLY
  logic [CNT_W-1:0]     r_out_cnt;    // pixels delivered in APPLY
  logic [CNT_W-1:0]     r_cum;        // running cumulative count
  logic                 r_out_valid;
  logic [PIXEL_W-1:0]   r_out_pixel;
  logic [CNT_W-1:0]     r_bins [L];
  logic [PIXEL_W-1:0]   r_lut  [L];

  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [CNT_W-1:0]     w_cum_new;
  logic [PROD_W-1:0]    w_prod;
  logic [PIXEL_W-1:0]   w_lut_val;

  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready;

  // cum never exceeds N, so CNT_W+PIXEL_W bits hold cum*(L-1) without overflow.
  assign w_cum_new = r_cum + r_bins[r_idx];
  assign w_prod    = PROD_W'(w_cum_new) * L_MAX;
  assign w_lut_val = w_prod[PIX_CNT_LOG2 +: PIXEL_W];

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign phase     = r_state;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CLEAR;
      S_CLEAR: if (r_idx == IDX_LAST) w_next_state = S_ACCUM;
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == N_LAST)) w_next_state = S_CDF;
      end
      S_CDF:   if (r_idx == IDX_LAST) w_next_state = S_APPLY;
      S_APPLY: begin
        // Stop taking pixels once N are in; the last output may still be stalled.
        in_ready = (r_cnt != N_CNT) && (!r_out_valid || out_ready);
        if (w_out_hs && (r_out_cnt == N_LAST)) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_cnt   <= '0;
      r_cum       <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && start) r_mode <= mode;

      // Every counter restarts from zero on entry to a new phase.
      if (w_next_state != r_state) begin
        r_idx     <= '0;
        r_cnt     <= '0;
        r_out_cnt <= '0;
        r_cum     <= '0;
      end else begin
        case (r_state)
          S_CLEAR: r_idx <= r_idx + 1'b1;
          S_ACCUM: if (w_in_hs) r_cnt <= r_cnt + 1'b1;
          S_CDF: begin
            r_idx <= r_idx + 1'b1;
            r_cum <= w_cum_new;
          end
          S_APPLY: begin
            if (w_in_hs)  r_cnt     <= r_cnt + 1'b1;
            if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;
          end
          default: ;
        endcase
      end

      // Output register: load on input handshake, hold while stalled,
      // empty after an output handshake with nothing new behind it.
      if ((r_state == S_APPLY) && w_in_hs) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= r_lut[in_pixel];
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the bin and LUT arrays have no reset; CLEAR and CDF overwrite every
  // entry before it is read, so a reset port on them would only cost logic.
  always_ff @(posedge clk) begin
    case (r_state)
      S_CLEAR: r_bins[r_idx] <= '0;
      S_ACCUM: if (w_in_hs) r_bins[in_pixel] <= r_bins[in_pixel] + 1'b1;
      S_CDF:   r_lut[r_idx] <= r_mode ? r_idx : w_lut_val;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_histogram_equalizer_core.sv
// -----------------------------------------------------------------------------
// tb_histogram_equalizer_core
//
// Directed bench for histogram_equalizer_core with PIXEL_W=8, PIX_CNT_LOG2=4
// (16-pixel frames). Inputs are driven on the falling edge and outputs are
// sampled 1 ns later, well away from the rising edge. Expected pixels are
// hand-computed as (cum * 255) >> 4 per frame.
// -----------------------------------------------------------------------------
module tb_histogram_equalizer_core;

  localparam int PW   = 8;
  localparam int LOG2 = 4;
  localparam int CW   = LOG2 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic          in_valid;
  logic [PW-1:0] in_pixel;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_pixel;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [2:0]    phase;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int start_cyc;

  int acc_px [16];
  int app_px [16];
  int exp_px [16];

  histogram_equalizer_core #(
    .PIXEL_W      (PW),
    .PIX_CNT_LOG2 (LOG2),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .phase     (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then flip mode to show it was latched.
  task automatic pulse_start(input logic m);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    #1;
    check("start_phase_clear", 32'(phase), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  // Stream acc_px with in_valid held high; optionally pulse start mid-ACCUM.
  task automatic feed_accum(input bit mid_start);
    int  i = 0;
    int  guard = 0;
    bit  pulsed = 1'b0;
    bit  checked = 1'b0;
    while (i < 16 && guard < 1000) begin
      @(negedge clk);
      guard++;
      start    = (mid_start && i == 2 && !pulsed);
      if (start) pulsed = 1'b1;
      in_valid = 1'b1;
      in_pixel = 8'(acc_px[i]);
      #1;
      if (pulsed && !start && !checked) begin
        check("mid_accum_start_ignored", 32'(phase), 32'd2);
        checked = 1'b1;
      end
      if (in_ready) i++;
    end
    check("accum_count", 32'(i), 32'd16);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("cdf_phase", 32'(phase), 32'd3);
    check("cdf_in_ready_low", 32'(in_ready), 32'd0);
  endtask

  // Stream app_px, collect outputs, compare with exp_px, and wait for done.
  task automatic run_apply(input bit stall, input int exp_lat, input string tag);
    int         j = 0;
    int         k = 0;
    int         guard = 0;
    bit         got_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix = '0;
    while (!got_done && guard < 3000) begin
      @(negedge clk);
      guard++;
      out_ready = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
      in_valid  = (j < 16) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_pixel  = (j < 16) ? 8'(app_px[j]) : 8'd0;
      #1;
      if (prev_stall) begin
        check($sformatf("%s_hold_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s_hold_pixel", tag), 32'(out_pixel), 32'(prev_pix));
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pixel;
      if (in_valid && in_ready) j++;
      if (out_valid && out_ready) begin
        if (k < 16) check($sformatf("%s_out%0d", tag, k), 32'(out_pixel), 32'(exp_px[k]));
        k++;
      end
      if (done) begin
        got_done = 1'b1;
        if (exp_lat > 0) check($sformatf("%s_latency", tag), 32'(cyc - start_cyc + 1), 32'(exp_lat));
      end
    end
    in_valid = 1'b0;
    check($sformatf("%s_out_count", tag), 32'(k), 32'd16);
    check($sformatf("%s_done_seen", tag), 32'(got_done), 32'd1);
    @(negedge clk);
    #1;
    check($sformatf("%s_done_one_cycle", tag), 32'(done), 32'd0);
    check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_idle_phase", tag), 32'(phase), 32'd0);
  endtask

  task automatic load_ramp_frame();
    // Pixels 0..15 once each: cum(p) = p+1, lut[p] = (p+1)*255 >> 4; lut[>=15] = 255.
    acc_px = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    app_px = '{0, 7, 15, 200, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 255};
    exp_px = '{15, 127, 255, 255, 31, 47, 63, 79, 95, 111, 143, 159, 175, 191, 207, 255};
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Frame 1: all zeros -> bin[0]=16, every lut entry 255; no stalls.
    foreach (acc_px[i]) begin
      acc_px[i] = 0;
      app_px[i] = 0;
      exp_px[i] = 255;
    end
    pulse_start(1'b0);
    feed_accum(1'b0);
    run_apply(1'b0, 1 + 256 + 16 + 256 + 16 + 1 + 1, "zeros");

    // Frame 2: ramp 0..15, equalize.
    load_ramp_frame();
    pulse_start(1'b0);
    feed_accum(1'b0);
    run_apply(1'b0, 0, "ramp");

    // Frame 3: identity mode, arbitrary pixels pass through unchanged.
    acc_px = '{3, 200, 17, 255, 0, 128, 64, 99, 3, 3, 42, 7, 250, 1, 2, 180};
    app_px = '{3, 200, 17, 255, 0, 128, 64, 99, 3, 3, 42, 7, 250, 1, 2, 180};
    exp_px = '{3, 200, 17, 255, 0, 128, 64, 99, 3, 3, 42, 7, 250, 1, 2, 180};
    pulse_start(1'b1);
    feed_accum(1'b0);
    run_apply(1'b0, 0, "ident");

    // Frame 4: ramp frame, apply 15..0 with output stalls and input gaps.
    load_ramp_frame();
    app_px = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    exp_px = '{255, 239, 223, 207, 191, 175, 159, 143, 127, 111, 95, 79, 63, 47, 31, 15};
    pulse_start(1'b0);
    feed_accum(1'b0);
    run_apply(1'b1, 0, "stall");

    // Frame 5: five consecutive 9s; cum(8)=8 -> 127, cum(9)=13 -> 207.
    // Other pixels 0..7,12,13,14 once: cum(12)=14 -> 223, cum(13)=15 -> 239.
    acc_px = '{0, 9, 9, 9, 9, 9, 1, 2, 3, 4, 5, 6, 7, 12, 13, 14};
    app_px = '{8, 9, 10, 11, 12, 13, 14, 15, 0, 7, 9, 9, 8, 200, 3, 9};
    exp_px = '{127, 207, 207, 207, 223, 239, 255, 255, 15, 127, 207, 207, 127, 255, 63, 207};
    pulse_start(1'b0);
    feed_accum(1'b1);
    run_apply(1'b0, 0, "nines");

    // Frame 6: abort during CDF with all-255 pixels, then a clean ramp frame.
    foreach (acc_px[i]) acc_px[i] = 255;
    pulse_start(1'b0);
    feed_accum(1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_phase", 32'(phase), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load_ramp_frame();
    pulse_start(1'b0);
    feed_accum(1'b0);
    run_apply(1'b0, 0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
